// File: rtl/router_top.sv
// router_top: three-port packet router. A byte-serial packet (header, payload,
// parity) is steered by the header address into one of three output FIFOs.
// The parity of each packet is checked, and error reports the result.
// Optional feature macro: ROUTER_SOFT_RESET_EN. When it is defined, each port
// flushes its FIFO after TIMEOUT cycles of unread data.

module router_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_flush,
    input  logic       i_we,
    input  logic [7:0] i_wdata,
    input  logic       i_re,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_rdata;
    logic          w_do_wr;
    logic          w_do_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_do_wr = i_we && !o_full && !i_flush;
    assign w_do_rd = i_re && !o_empty && !i_flush;
    assign o_rdata = r_rdata;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Wrap-around pointers and occupancy count; a flush empties the FIFO at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read data: loads the oldest byte on a successful read, else holds.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_do_rd) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end
endmodule

module router_top #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2,
    output logic       busy,
    output logic       error
);
    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd1;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd2;
    localparam logic [2:0] LOAD_DATA          = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
    localparam logic [2:0] DISCARD            = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_header;
    logic [1:0] r_addr;
    logic [7:0] r_parity;
    logic [7:0] r_rx_parity;
    logic [7:0] r_hold_data;
    logic       r_hold_valid;
    logic       r_error;

    logic [2:0] w_we;
    logic [2:0] w_re;
    logic [2:0] w_empty;
    logic [2:0] w_full;
    logic [2:0] w_flush;
    logic [7:0] w_rdata [3];
    logic       w_write;
    logic [7:0] w_wdata;
    logic       w_tgt_full;
    logic       w_tgt_empty;
    logic       w_tgt_flush;
    logic       w_hdr_empty;
    logic       w_writing;

    assign w_re = {read_enb_2, read_enb_1, read_enb_0};

    // Status of the FIFO selected by the latched address, and of the FIFO named
    // by the header currently on data_in (used before the address is latched).
    always_comb begin
        w_tgt_full  = 1'b0;
        w_tgt_empty = 1'b0;
        w_tgt_flush = 1'b0;
        w_hdr_empty = 1'b0;
        case (r_addr)
            2'd0:    begin w_tgt_full = w_full[0]; w_tgt_empty = w_empty[0]; w_tgt_flush = w_flush[0]; end
            2'd1:    begin w_tgt_full = w_full[1]; w_tgt_empty = w_empty[1]; w_tgt_flush = w_flush[1]; end
            2'd2:    begin w_tgt_full = w_full[2]; w_tgt_empty = w_empty[2]; w_tgt_flush = w_flush[2]; end
            default: begin w_tgt_full = 1'b0;      w_tgt_empty = 1'b0;       w_tgt_flush = 1'b0;       end
        endcase
        case (data_in[1:0])
            2'd0:    w_hdr_empty = w_empty[0];
            2'd1:    w_hdr_empty = w_empty[1];
            2'd2:    w_hdr_empty = w_empty[2];
            default: w_hdr_empty = 1'b0;
        endcase
    end

    assign w_writing = (r_state == LOAD_FIRST_DATA) || (r_state == LOAD_DATA) ||
                       (r_state == FIFO_FULL_STATE) || (r_state == LOAD_AFTER_FULL);

    // Next-state and FIFO write selection; a timeout flush of the port being
    // written abandons the packet and returns to header decoding.
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_wdata = data_in;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) begin
                        w_next = DISCARD;
                    end else if (w_hdr_empty) begin
                        w_next = LOAD_FIRST_DATA;
                    end else begin
                        w_next = WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (w_tgt_empty) begin
                    w_next = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                w_write = 1'b1;
                w_wdata = r_header;
                w_next  = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (!w_tgt_full) begin
                    w_write = 1'b1;
                    if (!pkt_valid) begin
                        w_next = CHECK_PARITY_ERROR;
                    end
                end else begin
                    w_next = FIFO_FULL_STATE;
                end
            end
            FIFO_FULL_STATE: begin
                if (!w_tgt_full) begin
                    w_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                w_write = 1'b1;
                w_wdata = r_hold_data;
                w_next  = r_hold_valid ? LOAD_DATA : CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                w_next = DECODE_ADDRESS;
            end
            DISCARD: begin
                if (!pkt_valid) begin
                    w_next = DECODE_ADDRESS;
                end
            end
            default: begin
                w_next = DECODE_ADDRESS;
            end
        endcase
        if (w_writing && w_tgt_flush) begin
            w_next = DECODE_ADDRESS;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next;
        end
    end

    // Header latch, running/received parity, full-stall hold byte and error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_header     <= '0;
            r_addr       <= '0;
            r_parity     <= '0;
            r_rx_parity  <= '0;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid) begin
                        r_header <= data_in;
                        r_addr   <= data_in[1:0];
                    end
                end
                LOAD_FIRST_DATA: begin
                    r_error  <= 1'b0;
                    r_parity <= r_header;
                end
                LOAD_DATA: begin
                    if (!w_tgt_full) begin
                        if (pkt_valid) begin
                            r_parity <= r_parity ^ data_in;
                        end else begin
                            r_rx_parity <= data_in;
                        end
                    end else begin
                        r_hold_data  <= data_in;
                        r_hold_valid <= pkt_valid;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (r_hold_valid) begin
                        r_parity <= r_parity ^ r_hold_data;
                    end else begin
                        r_rx_parity <= r_hold_data;
                    end
                end
                CHECK_PARITY_ERROR: begin
                    r_error <= (r_parity != r_rx_parity);
                end
                default: begin
                    r_error <= r_error;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_port
        assign w_we[g] = w_write && (r_addr == 2'(g));

        router_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .resetn  (resetn),
            .i_flush (w_flush[g]),
            .i_we    (w_we[g]),
            .i_wdata (w_wdata),
            .i_re    (w_re[g]),
            .o_rdata (w_rdata[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
    end

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    for (genvar t = 0; t < 3; t++) begin : g_timer
        logic [TW-1:0] r_timer;

        // Counts cycles of unread data on this port; reaching TIMEOUT flushes it.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_timer <= '0;
            end else if (w_flush[t]) begin
                r_timer <= '0;
            end else if (!w_empty[t] && !w_re[t]) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end

        assign w_flush[t] = (r_timer == TW'(TIMEOUT));
    end
`else
    assign w_flush = 3'b000;
`endif

    assign busy = (r_state == WAIT_TILL_EMPTY) || (r_state == LOAD_FIRST_DATA) ||
                  (r_state == FIFO_FULL_STATE) || (r_state == LOAD_AFTER_FULL) ||
                  (r_state == CHECK_PARITY_ERROR);
    assign error       = r_error;
    assign data_out_0  = w_rdata[0];
    assign data_out_1  = w_rdata[1];
    assign data_out_2  = w_rdata[2];
    assign valid_out_0 = !w_empty[0];
    assign valid_out_1 = !w_empty[1];
    assign valid_out_2 = !w_empty[2];
endmodule

// File: tb/tb_router_top.sv
// tb_router_top: randomized self-checking bench for router_top. Expected FIFO
// contents are kept as per-port byte queues filled from the packet format and
// expected error comes from XOR-ing each packet directly.
`timescale 1ns/1ps

module tb_router_top;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb_0 = 1'b0;
    logic       read_enb_1 = 1'b0;
    logic       read_enb_2 = 1'b0;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       valid_out_2;
    logic       busy;
    logic       error;

    int tests_run = 0;
    int fail_count = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic       model_error = 1'b0;

    router_top #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .read_enb_0  (read_enb_0),
        .read_enb_1  (read_enb_1),
        .read_enb_2  (read_enb_2),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .valid_out_2 (valid_out_2),
        .busy        (busy),
        .error       (error)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Hard stop in case some wait escapes its own bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired tests_run=%0d", tests_run);
        $fatal(1, "[TB] watchdog");
    end

    function automatic void model_push(input int p, input logic [7:0] b);
        case (p)
            0: q0.push_back(b);
            1: q1.push_back(b);
            2: q2.push_back(b);
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] model_pop(input int p);
        logic [7:0] b;
        b = 8'hxx;
        case (p)
            0: if (q0.size() > 0) b = q0.pop_front();
            1: if (q1.size() > 0) b = q1.pop_front();
            2: if (q2.size() > 0) b = q2.pop_front();
            default: ;
        endcase
        return b;
    endfunction

    function automatic int model_size(input int p);
        case (p)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return 0;
        endcase
    endfunction

    function automatic logic get_valid(input int p);
        case (p)
            0: return valid_out_0;
            1: return valid_out_1;
            2: return valid_out_2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] get_data(input int p);
        case (p)
            0: return data_out_0;
            1: return data_out_1;
            2: return data_out_2;
            default: return 8'h00;
        endcase
    endfunction

    task automatic set_read(input int p, input logic v);
        case (p)
            0: read_enb_0 = v;
            1: read_enb_1 = v;
            2: read_enb_2 = v;
            default: ;
        endcase
    endtask

    // Present one byte and hold it until the router accepts it (busy low at an edge).
    task automatic drive_byte(input logic [7:0] b, input logic v, output bit stalled);
        int guard;
        guard   = 0;
        stalled = 1'b0;
        data_in   = b;
        pkt_valid = v;
        @(negedge clock);
        while (busy === 1'b1 && guard < 300) begin
            stalled = 1'b1;
            guard++;
            @(negedge clock);
        end
        if (guard >= 300) begin
            tests_run++;
            fail_count++;
            $display("[TB] FAIL drive_timeout byte=%02h busy stayed %b, required 0 within 300 cycles", b, busy);
        end
        @(posedge clock);
        #1;
    endtask

    // Send a packet with random payload; the model records the bytes and error.
    task automatic send_packet(input int len, input logic [1:0] addr, input bit corrupt, output bit any_stall);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        bit         st;
        hdr = {6'(len), addr};
        par = hdr;
        any_stall = 1'b0;
        if (addr != 2'd3) model_push(int'(addr), hdr);
        drive_byte(hdr, 1'b1, st);
        any_stall |= st;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            if (addr != 2'd3) model_push(int'(addr), b);
            drive_byte(b, 1'b1, st);
            any_stall |= st;
        end
        b = corrupt ? (par ^ 8'($urandom_range(1, 255))) : par;
        if (addr != 2'd3) begin
            model_push(int'(addr), b);
            model_error = (b != par);
        end
        drive_byte(b, 1'b0, st);
        any_stall |= st;
    endtask

    // Read n bytes from port p, comparing each against the model queue.
    task automatic drain_port(input int p, input int n, input bit check_tail);
        logic [7:0] exp_b;
        exp_b = 8'h00;
        set_read(p, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            tests_run++;
            if (get_valid(p) !== 1'b1) begin
                fail_count++;
                $display("[TB] FAIL drain_valid port=%0d item=%0d got=%b required=1", p, i, get_valid(p));
            end
            exp_b = model_pop(p);
            @(posedge clock);
            #1;
            tests_run++;
            if (get_data(p) !== exp_b) begin
                fail_count++;
                $display("[TB] FAIL drain_data port=%0d item=%0d got=%02h required=%02h", p, i, get_data(p), exp_b);
            end
        end
        set_read(p, 1'b0);
        if (check_tail) begin
            @(posedge clock);
            #1;
            tests_run++;
            if (get_valid(p) !== (model_size(p) != 0)) begin
                fail_count++;
                $display("[TB] FAIL drain_tail_valid port=%0d got=%b required=%b", p, get_valid(p), model_size(p) != 0);
            end
            tests_run++;
            if (get_data(p) !== exp_b) begin
                fail_count++;
                $display("[TB] FAIL data_out_hold port=%0d got=%02h required=%02h", p, get_data(p), exp_b);
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({busy, error, valid_out_0, valid_out_1, valid_out_2} !== 5'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_flags got busy=%b error=%b valid=%b%b%b required all 0",
                     busy, error, valid_out_2, valid_out_1, valid_out_0);
        end
        tests_run++;
        if ({data_out_0, data_out_1, data_out_2} !== 24'h0) begin
            fail_count++;
            $display("[TB] FAIL reset_data got %02h %02h %02h required 00 00 00", data_out_0, data_out_1, data_out_2);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_full_stall;
        bit st;
        send_packet(15, 2'd2, 1'b0, st);
        tests_run++;
        if (busy !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL full_busy got=%b required=1", busy);
        end
        tests_run++;
        if (valid_out_2 !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL full_valid2 got=%b required=1", valid_out_2);
        end
        drain_port(2, 17, 1'b1);
        tests_run++;
        if (error !== model_error) begin
            fail_count++;
            $display("[TB] FAIL full_error got=%b required=%b", error, model_error);
        end
    endtask

    task automatic test_parity_error;
        bit st;
        model_push(1, 8'h05);
        model_push(1, 8'hAA);
        model_push(1, 8'h00);
        model_error = 1'b1;
        drive_byte(8'h05, 1'b1, st);
        drive_byte(8'hAA, 1'b1, st);
        drive_byte(8'h00, 1'b0, st);
        @(posedge clock);
        #1;
        tests_run++;
        if (error !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL parity_error got=%b required=1", error);
        end
        drain_port(1, 3, 1'b1);
        tests_run++;
        if (error !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL parity_error_hold got=%b required=1", error);
        end
    endtask

    task automatic test_reset_mid_packet;
        bit st;
        drive_byte({6'd5, 2'd0}, 1'b1, st);
        drive_byte(8'h5A, 1'b1, st);
        drive_byte(8'hC3, 1'b1, st);
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        model_error = 1'b0;
        @(posedge clock);
        #1;
        tests_run++;
        if ({busy, error, valid_out_0, valid_out_1, valid_out_2} !== 5'b0) begin
            fail_count++;
            $display("[TB] FAIL midreset_flags got busy=%b error=%b valid=%b%b%b required all 0",
                     busy, error, valid_out_2, valid_out_1, valid_out_0);
        end
        tests_run++;
        if ({data_out_0, data_out_1, data_out_2} !== 24'h0) begin
            fail_count++;
            $display("[TB] FAIL midreset_data got %02h %02h %02h required 00 00 00", data_out_0, data_out_1, data_out_2);
        end
        pkt_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        send_packet(3, 2'd0, 1'b0, st);
        @(posedge clock);
        #1;
        tests_run++;
        if (error !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL restart_error got=%b required=0", error);
        end
        drain_port(0, 5, 1'b1);
    endtask

    task automatic test_invalid_addr;
        bit st;
        send_packet(2, 2'd3, 1'b0, st);
        tests_run++;
        if (st !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL discard_busy got stall=%b required=0", st);
        end
        @(posedge clock);
        #1;
        tests_run++;
        if ({busy, valid_out_0, valid_out_1, valid_out_2} !== 4'b0) begin
            fail_count++;
            $display("[TB] FAIL discard_state got busy=%b valid=%b%b%b required all 0",
                     busy, valid_out_2, valid_out_1, valid_out_0);
        end
        send_packet(4, 2'd1, 1'b0, st);
        @(posedge clock);
        #1;
        tests_run++;
        if (error !== model_error) begin
            fail_count++;
            $display("[TB] FAIL after_discard_error got=%b required=%b", error, model_error);
        end
        drain_port(1, 6, 1'b1);
    endtask

    task automatic test_wait_occupied;
        bit st;
        bit st2;
        int bad;
        send_packet(2, 2'd0, 1'b0, st);
        @(posedge clock);
        #1;
        fork
            begin
                send_packet(3, 2'd0, 1'b1, st2);
            end
            begin
                repeat (2) @(negedge clock);
                bad = 0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    if (busy !== 1'b1) bad++;
                end
                tests_run++;
                if (bad != 0) begin
                    fail_count++;
                    $display("[TB] FAIL wait_busy got busy low on %0d of 8 cycles required 0", bad);
                end
                @(posedge clock);
                #1;
                drain_port(0, 4, 1'b0);
            end
        join
        @(posedge clock);
        #1;
        tests_run++;
        if (error !== model_error) begin
            fail_count++;
            $display("[TB] FAIL wait_error got=%b required=%b", error, model_error);
        end
        drain_port(0, 5, 1'b1);
    endtask

    task automatic test_back_to_back;
        bit st;
        int a;
        int b;
        int la;
        int lb;
        a  = int'($urandom_range(0, 2));
        b  = (a + int'($urandom_range(1, 2))) % 3;
        la = int'($urandom_range(1, 6));
        lb = int'($urandom_range(1, 6));
        send_packet(la, 2'(a), 1'b0, st);
        send_packet(lb, 2'(b), 1'b1, st);
        @(posedge clock);
        #1;
        tests_run++;
        if (error !== model_error) begin
            fail_count++;
            $display("[TB] FAIL b2b_error got=%b required=%b", error, model_error);
        end
        tests_run++;
        if (get_valid(a) !== 1'b1 || get_valid(b) !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL b2b_valid got port%0d=%b port%0d=%b required 1 1", a, get_valid(a), b, get_valid(b));
        end
        drain_port(a, la + 2, 1'b1);
        drain_port(b, lb + 2, 1'b1);
    endtask

    task automatic test_random;
        bit st;
        int len;
        logic [1:0] addr;
        bit corrupt;
        for (int it = 0; it < 16; it++) begin
            len     = int'($urandom_range(1, 14));
            addr    = 2'($urandom_range(0, 3));
            corrupt = 1'($urandom_range(0, 1));
            send_packet(len, addr, corrupt, st);
            @(posedge clock);
            #1;
            tests_run++;
            if (busy !== 1'b0 || error !== model_error) begin
                fail_count++;
                $display("[TB] FAIL random_status iter=%0d got busy=%b error=%b required busy=0 error=%b",
                         it, busy, error, model_error);
            end
            if (addr == 2'd3) begin
                tests_run++;
                if ({valid_out_0, valid_out_1, valid_out_2} !== 3'b0) begin
                    fail_count++;
                    $display("[TB] FAIL random_discard iter=%0d got valid=%b%b%b required 000",
                             it, valid_out_2, valid_out_1, valid_out_0);
                end
            end else begin
                drain_port(int'(addr), len + 2, 1'b1);
            end
        end
    endtask

    task automatic test_soft_reset;
        bit st;
        logic exp_v;
        send_packet(2, 2'd0, 1'b0, st);
        repeat (40) @(posedge clock);
        #1;
`ifdef ROUTER_SOFT_RESET_EN
        exp_v = 1'b0;
        q0.delete();
`else
        exp_v = 1'b1;
`endif
        tests_run++;
        if (valid_out_0 !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL timeout_valid0 got=%b required=%b", valid_out_0, exp_v);
        end
        if (model_size(0) != 0) drain_port(0, model_size(0), 1'b1);
    endtask

    initial begin
        test_reset;
        test_full_stall;
        test_parity_error;
        test_reset_mid_packet;
        test_invalid_addr;
        test_wait_occupied;
        test_back_to_back;
        test_random;
        test_soft_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
